spi_cmd_ctrl: RTL and testbench
===============================

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter N_CONTACTORS, default 8, the number of contactor slots (1..255).
REQ-002 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset, synchronous and active-high.
REQ-004 SHALL have port cs_active_i, input, 1 bit; SPI frame in progress.
REQ-005 SHALL have port rx_valid_i, input, 1 bit; a received byte is present for one cycle.
REQ-006 SHALL have port rx_data_i, input, 8 bits; the received byte.
REQ-007 SHALL have port tx_data_o, output, 8 bits; the response byte for the shifter.
REQ-008 SHALL have port tx_load_o, output, 1 bit; 1-cycle pulse that loads tx_data_o into the shifter.
REQ-009 SHALL have port feedback_i, input, 2*N_CONTACTORS bits; bits [2i+1:2i] = {plus, minus} feedback of contactor i.
REQ-010 SHALL have port fb_timeout_i, input, 1 bit; 1-cycle feedback-timeout event.
REQ-011 SHALL have port contactor_cmd_o, output, N_CONTACTORS bits; contactor close commands.
REQ-012 SHALL have ports shutdown_o and pg_shutdown_o, outputs, 1 bit each; shutdown request and direct PG shutdown.
REQ-013 SHALL have port soft_reset_o, output, 1 bit; 1-cycle reset-request pulse.

Function
REQ-014 Frame format SHALL be: byte0 = command, byte1 = index, byte2 = write data for writes or response slot for reads.
REQ-015 FSM states SHALL be IDLE, GET_IDX, GET_DATA, SEND_RESP and DRAIN; any state SHALL go to IDLE in the cycle after cs_active_i is 0.
REQ-016 IDLE: on rx_valid_i with cs_active_i=1, a valid command SHALL be latched and the FSM SHALL go to GET_IDX.
REQ-017 IDLE: an invalid command byte (any value other than 0x01-0x04 or 0x81-0x84) SHALL set invalid_request and the FSM SHALL go to DRAIN.
REQ-018 GET_IDX: on rx_valid_i the index SHALL be latched; writes SHALL go to GET_DATA and reads SHALL go to SEND_RESP.
REQ-019 SEND_RESP: tx_data_o SHALL be set and tx_load_o pulsed exactly one cycle after the index byte's rx_valid_i; tx_data_o SHALL then hold until the next load; the FSM SHALL then go to DRAIN.
REQ-020 Read 0x01 SHALL return {7'b0, contactor_cmd_o[idx]}.
REQ-021 Read 0x02 SHALL return {6'b0, feedback_i[2idx+1:2idx]}, sampled in the load cycle.
REQ-022 Read 0x03 SHALL return {fb_timeout_err, invalid_request, 6'b0}, with index ignored.
REQ-023 Read 0x04 SHALL return {6'b0, pg_shutdown_o, shutdown_o}, with index ignored.
REQ-024 GET_DATA: on rx_valid_i the write SHALL take effect at the next clock edge and the FSM SHALL go to DRAIN.
REQ-025 Write 0x81 SHALL set contactor_cmd_o[idx] = data[0].
REQ-026 Write 0x82 SHALL behave as follows: data[0]=1 pulses soft_reset_o for one cycle; data[1]=1 clears both error flags; bits [7:2] SHALL be ignored.
REQ-027 Write 0x83 SHALL set shutdown_o = data[0].
REQ-028 Write 0x84 SHALL set pg_shutdown_o = data[0].
REQ-029 For 0x01, 0x02 and 0x81, idx >= N_CONTACTORS SHALL set invalid_request; reads SHALL return 0x00 and writes SHALL have no effect.
REQ-030 DRAIN SHALL ignore all further bytes until cs_active_i is 0.
REQ-031 A frame aborted (cs_active_i = 0) before its data byte SHALL apply no write and SHALL NOT set invalid_request.
REQ-032 fb_timeout_i=1 SHALL set fb_timeout_err; both error flags SHALL be sticky.
REQ-033 If a set event and a clear_errors write hit the same cycle, set SHALL win.
REQ-034 tx_load_o SHALL pulse only in SEND_RESP, at most once per frame.

Reset
REQ-035 When rst=1 at a clock edge: FSM = IDLE; contactor_cmd_o = 0; shutdown_o = 0; pg_shutdown_o = 0; tx_data_o = 0x00; tx_load_o = 0; soft_reset_o = 0; both error flags = 0.
REQ-036 Reset mid-frame SHALL discard the frame; after reset releases, the FSM SHALL stay in DRAIN-equivalent idle until cs_active_i is 0.
REQ-037 soft_reset_o SHALL NOT reset this block.

Verification
REQ-038 Frame 0x81, 0x02, 0x01 with N=8 -> contactor_cmd_o = 0x04 one cycle after the third rx_valid_i; invalid_request = 0.
REQ-039 feedback_i[5:4] = 2'b10, frame 0x02, 0x02 -> tx_load_o pulses one cycle after the index byte with tx_data_o = 0x02.
REQ-040 Frame 0x55 -> invalid_request = 1; a following 0x03 read -> tx_data_o = 0x40; then 0x82, xx, 0x02 -> 0x03 read returns 0x00.
REQ-041 Frame 0x81, 0x09, 0x01 with N=8 -> contactor_cmd_o unchanged, invalid_request = 1; frame 0x01, 0x09 -> tx_data_o = 0x00.
REQ-042 fb_timeout_i pulsed in the same cycle as a clear_errors write -> fb_timeout_err = 1; 0x03 read -> tx_data_o = 0x80.
REQ-043 Frame 0x83, 0x00, then cs_active_i dropped before the data byte -> shutdown_o stays 0; the next frame 0x83, 0x00, 0x01 -> shutdown_o = 1.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder for the contactor controller: each frame carries a command,
// an index and either write data or a slot for the single response byte.
module spi_cmd_ctrl #(
    parameter int unsigned N_CONTACTORS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cs_active_i,
    input  logic                        rx_valid_i,
    input  logic [7:0]                  rx_data_i,
    output logic [7:0]                  tx_data_o,
    output logic                        tx_load_o,
    input  logic [2*N_CONTACTORS-1:0]   feedback_i,
    input  logic                        fb_timeout_i,
    output logic [N_CONTACTORS-1:0]     contactor_cmd_o,
    output logic                        shutdown_o,
    output logic                        pg_shutdown_o,
    output logic                        soft_reset_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_IDX   = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_SEND_RESP = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

    localparam logic [7:0] CMD_RD_CONTACTOR   = 8'h01;
    localparam logic [7:0] CMD_RD_FEEDBACK    = 8'h02;
    localparam logic [7:0] CMD_RD_STATUS      = 8'h03;
    localparam logic [7:0] CMD_RD_SHUTDOWN    = 8'h04;
    localparam logic [7:0] CMD_WR_CONTACTOR   = 8'h81;
    localparam logic [7:0] CMD_WR_CONTROL     = 8'h82;
    localparam logic [7:0] CMD_WR_SHUTDOWN    = 8'h83;
    localparam logic [7:0] CMD_WR_PG_SHUTDOWN = 8'h84;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        logic known_s;
        case (cmd)
            CMD_RD_CONTACTOR, CMD_RD_FEEDBACK, CMD_RD_STATUS, CMD_RD_SHUTDOWN,
            CMD_WR_CONTACTOR, CMD_WR_CONTROL, CMD_WR_SHUTDOWN, CMD_WR_PG_SHUTDOWN:
                known_s = 1'b1;
            default: known_s = 1'b0;
        endcase
        return known_s;
    endfunction

    function automatic logic uses_index(input logic [7:0] cmd);
        logic uses_s;
        case (cmd)
            CMD_RD_CONTACTOR, CMD_RD_FEEDBACK, CMD_WR_CONTACTOR: uses_s = 1'b1;
            default: uses_s = 1'b0;
        endcase
        return uses_s;
    endfunction

    function automatic logic idx_in_range(input logic [7:0] idx);
        return ({24'd0, idx} < N_CONTACTORS);
    endfunction

    state_t                  state_r, state_s;
    logic [7:0]              cmd_r, cmd_s;
    logic [7:0]              idx_r, idx_s;
    logic [N_CONTACTORS-1:0] contactor_cmd_r, contactor_cmd_s;
    logic                    shutdown_r, shutdown_s;
    logic                    pg_shutdown_r, pg_shutdown_s;
    logic [7:0]              tx_data_r, tx_data_s;
    logic                    tx_load_r, tx_load_s;
    logic                    soft_reset_r, soft_reset_s;
    logic                    invalid_request_r, invalid_request_s;
    logic                    fb_timeout_err_r, fb_timeout_err_s;
    logic                    wait_cs_low_r, wait_cs_low_s;
    logic                    inv_set_s;
    logic                    clr_err_s;
    logic                    rd_bit_s;
    logic [1:0]              rd_fb_s;
    logic [7:0]              rd_resp_s;

    // Response byte for a read, indexed by the byte arriving now; out-of-range picks nothing
    always_comb begin
        rd_bit_s = 1'b0;
        rd_fb_s  = 2'b00;
        for (int i = 0; i < N_CONTACTORS; i++) begin
            rd_bit_s = rd_bit_s | (contactor_cmd_r[i] & (rx_data_i == 8'(i)));
            rd_fb_s  = rd_fb_s | (feedback_i[2*i +: 2] & {2{rx_data_i == 8'(i)}});
        end
        case (cmd_r)
            CMD_RD_CONTACTOR: rd_resp_s = {7'd0, rd_bit_s};
            CMD_RD_FEEDBACK:  rd_resp_s = {6'd0, rd_fb_s};
            CMD_RD_STATUS:    rd_resp_s = {fb_timeout_err_r, invalid_request_r, 6'd0};
            CMD_RD_SHUTDOWN:  rd_resp_s = {6'd0, pg_shutdown_r, shutdown_r};
            default:          rd_resp_s = 8'h00;
        endcase
    end

    // Next-state and next-register logic of the frame decoder
    always_comb begin
        state_s         = state_r;
        cmd_s           = cmd_r;
        idx_s           = idx_r;
        contactor_cmd_s = contactor_cmd_r;
        shutdown_s      = shutdown_r;
        pg_shutdown_s   = pg_shutdown_r;
        tx_data_s       = tx_data_r;
        tx_load_s       = 1'b0;
        soft_reset_s    = 1'b0;
        inv_set_s       = 1'b0;
        clr_err_s       = 1'b0;
        wait_cs_low_s   = wait_cs_low_r & cs_active_i;
        if (!cs_active_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // after a reset inside a frame, the rest of that frame is ignored
                    if (rx_valid_i && !wait_cs_low_r) begin
                        if (is_known_cmd(rx_data_i)) begin
                            cmd_s   = rx_data_i;
                            state_s = ST_GET_IDX;
                        end else begin
                            inv_set_s = 1'b1;
                            state_s   = ST_DRAIN;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_GET_IDX: begin
                    if (rx_valid_i) begin
                        idx_s = rx_data_i;
                        if (cmd_r[7]) begin
                            state_s = ST_GET_DATA;
                        end else begin
                            state_s   = ST_SEND_RESP;
                            tx_load_s = 1'b1;
                            tx_data_s = rd_resp_s;
                            inv_set_s = uses_index(cmd_r) & ~idx_in_range(rx_data_i);
                        end
                    end else begin
                        state_s = ST_GET_IDX;
                    end
                end
                ST_GET_DATA: begin
                    if (rx_valid_i) begin
                        state_s = ST_DRAIN;
                        case (cmd_r)
                            CMD_WR_CONTACTOR: begin
                                if (idx_in_range(idx_r)) begin
                                    for (int i = 0; i < N_CONTACTORS; i++) begin
                                        contactor_cmd_s[i] = (idx_r == 8'(i)) ? rx_data_i[0]
                                                                              : contactor_cmd_r[i];
                                    end
                                end else begin
                                    inv_set_s = 1'b1;
                                end
                            end
                            CMD_WR_CONTROL: begin
                                soft_reset_s = rx_data_i[0];
                                clr_err_s    = rx_data_i[1];
                            end
                            CMD_WR_SHUTDOWN:    shutdown_s    = rx_data_i[0];
                            CMD_WR_PG_SHUTDOWN: pg_shutdown_s = rx_data_i[0];
                            default:            state_s       = ST_DRAIN;
                        endcase
                    end else begin
                        state_s = ST_GET_DATA;
                    end
                end
                ST_SEND_RESP: state_s = ST_DRAIN;
                ST_DRAIN:     state_s = ST_DRAIN;
                default:      state_s = ST_IDLE;
            endcase
        end
        // sticky flags: a set event in the same cycle beats a clear request
        invalid_request_s = inv_set_s | (invalid_request_r & ~clr_err_s);
        fb_timeout_err_s  = fb_timeout_i | (fb_timeout_err_r & ~clr_err_s);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame context, control outputs, response byte and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_r             <= 8'h00;
            idx_r             <= 8'h00;
            contactor_cmd_r   <= '0;
            shutdown_r        <= 1'b0;
            pg_shutdown_r     <= 1'b0;
            tx_data_r         <= 8'h00;
            tx_load_r         <= 1'b0;
            soft_reset_r      <= 1'b0;
            invalid_request_r <= 1'b0;
            fb_timeout_err_r  <= 1'b0;
            wait_cs_low_r     <= cs_active_i;
        end else begin
            cmd_r             <= cmd_s;
            idx_r             <= idx_s;
            contactor_cmd_r   <= contactor_cmd_s;
            shutdown_r        <= shutdown_s;
            pg_shutdown_r     <= pg_shutdown_s;
            tx_data_r         <= tx_data_s;
            tx_load_r         <= tx_load_s;
            soft_reset_r      <= soft_reset_s;
            invalid_request_r <= invalid_request_s;
            fb_timeout_err_r  <= fb_timeout_err_s;
            wait_cs_low_r     <= wait_cs_low_s;
        end
    end

    assign tx_data_o       = tx_data_r;
    assign tx_load_o       = tx_load_r;
    assign contactor_cmd_o = contactor_cmd_r;
    assign shutdown_o      = shutdown_r;
    assign pg_shutdown_o   = pg_shutdown_r;
    assign soft_reset_o    = soft_reset_r;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: a byte-position frame model checked every cycle, plus
// directed frames with hand-computed expectations and a randomized frame stream.
module tb_spi_cmd_ctrl;

    localparam int N   = 8;
    localparam int FBW = 2 * N;

    logic           clk = 1'b0;
    logic           rst;
    logic           cs_active;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic [7:0]     tx_data;
    logic           tx_load;
    logic [FBW-1:0] feedback;
    logic           fb_timeout;
    logic [N-1:0]   contactor_cmd;
    logic           shutdown;
    logic           pg_shutdown;
    logic           soft_reset;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(.N_CONTACTORS(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .cs_active_i     (cs_active),
        .rx_valid_i      (rx_valid),
        .rx_data_i       (rx_data),
        .tx_data_o       (tx_data),
        .tx_load_o       (tx_load),
        .feedback_i      (feedback),
        .fb_timeout_i    (fb_timeout),
        .contactor_cmd_o (contactor_cmd),
        .shutdown_o      (shutdown),
        .pg_shutdown_o   (pg_shutdown),
        .soft_reset_o    (soft_reset)
    );

    // Reference model: what the registers must hold, tracked by byte position in the frame
    logic [N-1:0] m_cmd  = '0;
    logic         m_shut = 1'b0;
    logic         m_pg   = 1'b0;
    logic         m_inv  = 1'b0;
    logic         m_fbto = 1'b0;
    logic         m_load = 1'b0;
    logic         m_soft = 1'b0;
    logic [7:0]   m_tx   = 8'h00;
    logic [7:0]   m_fcmd = 8'h00;
    int           m_fidx = 0;
    int           m_pos  = 0;
    bit           m_dead = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_cmd(input logic [7:0] b);
        return (b >= 8'h01 && b <= 8'h04) || (b >= 8'h81 && b <= 8'h84);
    endfunction

    task automatic model_step();
        bit inv_set = 1'b0;
        bit clr     = 1'b0;
        int idx;
        m_load = 1'b0;
        m_soft = 1'b0;
        if (rst) begin
            m_cmd = '0; m_shut = 1'b0; m_pg = 1'b0; m_inv = 1'b0; m_fbto = 1'b0;
            m_tx = 8'h00; m_pos = 0; m_dead = cs_active;
        end else begin
            if (!cs_active) begin
                m_pos  = 0;
                m_dead = 1'b0;
            end else if (rx_valid && !m_dead) begin
                if (m_pos == 0) begin
                    if (is_cmd(rx_data)) begin
                        m_fcmd = rx_data;
                        m_pos  = 1;
                    end else begin
                        inv_set = 1'b1;
                        m_dead  = 1'b1;
                    end
                end else if (m_pos == 1) begin
                    m_fidx = int'(rx_data);
                    idx    = m_fidx;
                    if (m_fcmd[7]) begin
                        m_pos = 2;
                    end else begin
                        m_load = 1'b1;
                        m_dead = 1'b1;
                        if (m_fcmd == 8'h01 || m_fcmd == 8'h02) begin
                            if (idx >= N) begin
                                inv_set = 1'b1;
                                m_tx    = 8'h00;
                            end else if (m_fcmd == 8'h01) begin
                                m_tx = {7'd0, m_cmd[idx]};
                            end else begin
                                m_tx = {6'd0, feedback[2*idx +: 2]};
                            end
                        end else if (m_fcmd == 8'h03) begin
                            m_tx = {m_fbto, m_inv, 6'd0};
                        end else begin
                            m_tx = {6'd0, m_pg, m_shut};
                        end
                    end
                end else begin
                    m_dead = 1'b1;
                    if (m_fcmd == 8'h81) begin
                        if (m_fidx >= N) inv_set = 1'b1;
                        else m_cmd[m_fidx] = rx_data[0];
                    end else if (m_fcmd == 8'h82) begin
                        m_soft = rx_data[0];
                        clr    = rx_data[1];
                    end else if (m_fcmd == 8'h83) begin
                        m_shut = rx_data[0];
                    end else begin
                        m_pg = rx_data[0];
                    end
                end
            end
            m_inv  = inv_set || (m_inv && !clr);
            m_fbto = fb_timeout || (m_fbto && !clr);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, just after the active edge
    always @(posedge clk) begin
        model_step();
        #1;
        check("tx_load_o",       32'(tx_load),       32'(m_load));
        check("tx_data_o",       32'(tx_data),       32'(m_tx));
        check("contactor_cmd_o", 32'(contactor_cmd), 32'(m_cmd));
        check("shutdown_o",      32'(shutdown),      32'(m_shut));
        check("pg_shutdown_o",   32'(pg_shutdown),   32'(m_pg));
        check("soft_reset_o",    32'(soft_reset),    32'(m_soft));
        check("invalid_request", 32'(dut.invalid_request_r), 32'(m_inv));
        check("fb_timeout_err",  32'(dut.fb_timeout_err_r),  32'(m_fbto));
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic to);
        rx_valid   = v;
        rx_data    = d;
        fb_timeout = to;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
        rx_valid = 1'b0;
    endtask

    task automatic frame_begin();
        cs_active = 1'b1;
        @(negedge clk);
    endtask

    task automatic frame_end();
        cs_active = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic write_frame(input logic [7:0] c, input logic [7:0] i, input logic [7:0] d);
        frame_begin();
        send_byte(c);
        send_byte(i);
        send_byte(d);
        frame_end();
    endtask

    task automatic read_frame(input string name, input logic [7:0] c, input logic [7:0] i,
                              input logic [7:0] exp);
        frame_begin();
        send_byte(c);
        send_byte(i);
        check({name, "_load"}, 32'(tx_load), 32'd1);
        check(name, 32'(tx_data), 32'(exp));
        frame_end();
    endtask

    function automatic logic rand_to();
        return ($urandom_range(0, 19) == 0);
    endfunction

    function automatic logic [7:0] pick_byte(input int pos);
        logic [7:0] b;
        if (pos == 0) begin
            if ($urandom_range(0, 99) < 85) b = {1'($urandom_range(0, 1)), 7'($urandom_range(1, 4))};
            else b = 8'($urandom);
        end else if (pos == 1) begin
            b = 8'($urandom_range(0, 11));
        end else begin
            b = 8'($urandom);
        end
        return b;
    endfunction

    initial begin
        int nb;
        int gap;
        rst = 1'b1; cs_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        feedback = '0; fb_timeout = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_tx_data",   32'(tx_data),       32'h00);
        check("reset_tx_load",   32'(tx_load),       32'd0);
        check("reset_contactor", 32'(contactor_cmd), 32'h00);
        check("reset_shutdown",  32'({pg_shutdown, shutdown, soft_reset}), 32'd0);

        // write contactor 2, visible one cycle after the data byte
        frame_begin();
        send_byte(8'h81); send_byte(8'h02); send_byte(8'h01);
        check("wr_contactor2", 32'(contactor_cmd), 32'h04);
        frame_end();
        read_frame("status_clean", 8'h03, 8'h00, 8'h00);

        feedback = 16'h0020;
        read_frame("rd_feedback2", 8'h02, 8'h02, 8'h02);
        read_frame("rd_contactor2", 8'h01, 8'h02, 8'h01);

        // bad command sets invalid_request, clear_errors removes it
        frame_begin(); send_byte(8'h55); frame_end();
        read_frame("status_invalid", 8'h03, 8'h00, 8'h40);
        write_frame(8'h82, 8'h00, 8'h02);
        read_frame("status_cleared", 8'h03, 8'h00, 8'h00);

        // out-of-range index
        write_frame(8'h81, 8'h09, 8'h01);
        check("oob_write_noeffect", 32'(contactor_cmd), 32'h04);
        read_frame("rd_oob", 8'h01, 8'h09, 8'h00);
        read_frame("status_oob", 8'h03, 8'h00, 8'h40);
        write_frame(8'h82, 8'h00, 8'h02);

        // timeout event in the same cycle as the clear request
        frame_begin();
        send_byte(8'h82); send_byte(8'h00);
        drive(1'b1, 8'h02, 1'b1);
        rx_valid = 1'b0; fb_timeout = 1'b0;
        frame_end();
        read_frame("status_set_wins", 8'h03, 8'h00, 8'h80);
        write_frame(8'h82, 8'h00, 8'h02);
        read_frame("status_cleared2", 8'h03, 8'h00, 8'h00);

        // aborted write, then a complete one
        frame_begin(); send_byte(8'h83); send_byte(8'h00); frame_end();
        check("abort_no_shutdown", 32'(shutdown), 32'd0);
        write_frame(8'h83, 8'h00, 8'h01);
        check("shutdown_set", 32'(shutdown), 32'd1);
        write_frame(8'h84, 8'h00, 8'h01);
        read_frame("rd_shutdowns", 8'h04, 8'h00, 8'h03);

        // soft reset pulse does not reset this block
        frame_begin();
        send_byte(8'h82); send_byte(8'h00); send_byte(8'h01);
        check("soft_reset_pulse", 32'(soft_reset), 32'd1);
        @(negedge clk);
        check("soft_reset_end", 32'(soft_reset), 32'd0);
        check("soft_keeps_contactor", 32'(contactor_cmd), 32'h04);
        frame_end();

        // reset mid-frame: remainder of the frame is ignored
        frame_begin();
        send_byte(8'h83);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h83); send_byte(8'h00); send_byte(8'h01);
        check("midreset_ignored", 32'(shutdown), 32'd0);
        frame_end();
        write_frame(8'h83, 8'h00, 8'h01);
        check("after_midreset", 32'(shutdown), 32'd1);

        // randomized frame stream against the model
        for (int f = 0; f < 400; f++) begin
            feedback  = FBW'($urandom);
            cs_active = 1'b1;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) drive(1'b0, 8'($urandom), rand_to());
                if ($urandom_range(0, 99) == 0) rst = 1'b1;
                drive(1'b1, pick_byte(b), rand_to());
                rst = 1'b0;
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive(1'b0, 8'($urandom), rand_to());
            cs_active = 1'b0;
            gap = $urandom_range(1, 2);
            for (int g = 0; g < gap; g++) drive(1'($urandom_range(0, 1)), pick_byte(0), rand_to());
            rx_valid = 1'b0; fb_timeout = 1'b0;
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
